// File: rtl/decoder_pkg.sv
// Shared types and helpers for the 5-to-32 streaming decoder.
package decoder_pkg;

  localparam int unsigned IDX_W = 5;
  localparam int unsigned OH_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic [OH_W-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return OH_W'(1) << idx;
  endfunction

endpackage

// File: rtl/decoder_5_to_32_stream.sv
// Streaming 5-to-32 one-hot decoder with a single output slot shared by the
// input path and an in-order scan of all 32 codes.
module decoder_5_to_32_stream
  import decoder_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic               scan_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OH_W-1:0]    out_onehot,
  output logic [IDX_W-1:0]   out_idx,
  output logic               busy,
  output logic [COUNT_W-1:0] dec_count
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   scan_cnt, scan_cnt_n;
  logic               valid_n;
  logic [OH_W-1:0]    onehot_n;
  logic [IDX_W-1:0]   idx_n;
  logic [COUNT_W-1:0] count_n;
  logic               slot_free;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && !scan_start && slot_free;
  assign busy      = (state == SCAN);

  // Next-state and slot load selection; scan_start takes priority over input.
  always_comb begin
    state_n    = state;
    scan_cnt_n = scan_cnt;
    valid_n    = out_valid;
    onehot_n   = out_onehot;
    idx_n      = out_idx;
    count_n    = dec_count;

    if (out_valid && out_ready) begin
      count_n = dec_count + COUNT_W'(1);
    end

    if (slot_free) begin
      valid_n  = 1'b0;
      onehot_n = '0;
      idx_n    = '0;
    end

    unique case (state)
      IDLE: begin
        if (scan_start) begin
          state_n    = SCAN;
          scan_cnt_n = '0;
        end else if (in_valid && in_ready) begin
          valid_n  = 1'b1;
          onehot_n = idx_to_onehot(in_idx);
          idx_n    = in_idx;
        end
      end
      SCAN: begin
        if (slot_free) begin
          valid_n    = 1'b1;
          onehot_n   = idx_to_onehot(scan_cnt);
          idx_n      = scan_cnt;
          scan_cnt_n = IDX_W'(scan_cnt + IDX_W'(1));
          if (scan_cnt == IDX_W'(OH_W - 1)) begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      scan_cnt   <= '0;
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_idx    <= '0;
      dec_count  <= '0;
    end else begin
      state      <= state_n;
      scan_cnt   <= scan_cnt_n;
      out_valid  <= valid_n;
      out_onehot <= onehot_n;
      out_idx    <= idx_n;
      dec_count  <= count_n;
    end
  end

endmodule

// File: doc/decoder_5_to_32_stream.md
DECODER_5_TO_32_STREAM -- requirements
Module: decoder_5_to_32_stream

Interface
REQ-001 Parameter: COUNT_W, default 16, width of the delivered-code counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  in_idx holds a valid index.
REQ-005 Port: in_ready  output  1  block accepts in_idx this cycle.
REQ-006 Port: in_idx  input  5  binary index 0..31 to decode.
REQ-007 Port: scan_start  input  1  single-cycle request to emit all 32 codes in order.
REQ-008 Port: out_valid  output  1  out_onehot/out_idx valid.
REQ-009 Port: out_ready  input  1  downstream accepts the output this cycle.
REQ-010 Port: out_onehot  output  32  one-hot code, bit out_idx set.
REQ-011 Port: out_idx  output  5  index that produced out_onehot.
REQ-012 Port: busy  output  1  high while in SCAN state.
REQ-013 Port: dec_count  output  COUNT_W  number of completed output handshakes.

Function
REQ-014 States IDLE and SCAN; one output register stage (slot) shared by both sources.
REQ-015 Slot is free when out_valid=0 or (out_valid=1 and out_ready=1) in the same cycle.
REQ-016 in_ready = (state==IDLE) and !scan_start and slot free; purely combinational, no dependency on in_valid.
REQ-017 Input transfer (in_valid and in_ready): next cycle out_valid=1, out_onehot=1<<in_idx, out_idx=in_idx; latency exactly 1 cycle; back-to-back transfers sustain one per cycle while out_ready=1.
REQ-018 out_valid, out_onehot, out_idx stay stable while out_valid=1 and out_ready=0.
REQ-019 On handshake with no reload in the same cycle: out_valid=0, out_onehot=0, out_idx=0 next cycle; out_onehot is all-zero whenever out_valid=0.
REQ-020 IDLE->SCAN when scan_start=1 in IDLE; scan_start beats a same-cycle in_valid (input not accepted); scan counter set to 0.
REQ-021 scan_start in SCAN is ignored; in_ready=0 throughout SCAN.
REQ-022 In SCAN, each cycle the slot is free: load 1<<scan_cnt and scan_cnt, then scan_cnt+1; loading index 31 returns state to IDLE next cycle.
REQ-023 A scan emits exactly 32 codes, indices 0..31 ascending, none skipped or repeated, regardless of out_ready stalls.
REQ-024 busy = (state==SCAN).
REQ-025 dec_count increments by 1 on every out_valid and out_ready cycle; wraps from 2^COUNT_W-1 to 0.
REQ-026 Output slot holding a code when scan_start arrives: that code is delivered first, scan code 0 follows.

Reset
REQ-027 rst=1 asynchronously forces: state=IDLE, scan_cnt=0, out_valid=0, out_onehot=0, out_idx=0, dec_count=0, busy=0.
REQ-028 Reset mid-scan aborts the scan; pending output discarded; no resumption after release.
REQ-029 First input transfer possible in first rising edge with rst=0.

Structure
REQ-030 Shared package decoder_pkg: IDX_W=5, OH_W=32, state enum {IDLE, SCAN}, pure function idx_to_onehot.
REQ-031 No sub-module; single module with combinational ready/slot logic and one sequential block.

Verification
REQ-032 in_idx=5'd0, 5'd17, 5'd31 back-to-back, out_ready=1 -> out_onehot 32'h00000001, 32'h00020000, 32'h80000000 on consecutive cycles, dec_count=3.
REQ-033 in_idx=5'd9 accepted, out_ready=0 for 4 cycles -> out_onehot=32'h00000200 stable, in_ready=0, dec_count unchanged until out_ready=1.
REQ-034 scan_start with in_valid same cycle, out_ready=1 -> input refused, 32 outputs 32'h1..32'h80000000, busy falls after index 31, dec_count=32.
REQ-035 scan with random out_ready stalls -> still 32 ascending indices, no duplicates; scan_start pulses during SCAN ignored.
REQ-036 rst asserted at scan index 12 -> immediately out_valid=0, busy=0, dec_count=0; next in_idx=5'd3 yields 32'h00000008.
REQ-037 COUNT_W=4, 17 handshakes -> dec_count=1 (wrap).
